pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the in-order RV32I pipeline.
- Drives the stall, insert_nop and flush controls of fetch, decode and execute.
- Keeps a per-register scoreboard of in-flight destination writes, so RAW and WAW hazards become NOP bubbles into execute.
- Sequences branch redirects and trap drains.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; max in-flight writers per register = 2^CNT_W-1.
- INF_W, 3, width of the total in-flight counter; must cover the pipeline depth.
- FLUSH_CYCLES, 1, number of cycles flush_fetch/flush_decode stay asserted after a redirect (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dec_instr  in  32  instruction currently at the decode input (instr_in)
- dec_valid  in  1  decode input valid
- ex_redirect  in  1  execute resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- wb_release_valid  in  1  one previously issued rd-writing instruction leaves the pipeline (committed or squashed)
- wb_release_rd  in  5  rd of the releasing instruction
- wb_exception  in  1  writeback commits an exception
- stall_fetch  out  1  hold fetch
- stall_decode  out  1  hold decode output register
- insert_nop  out  1  decode emits NOP to execute this cycle
- flush_fetch  out  1  kill fetch output
- flush_decode  out  1  kill decode output
- flush_execute  out  1  kill execute output
- trap_go  out  1  one-cycle pulse: pipeline drained, trap vector fetch may start
- stall_count  out  32  performance counter of cycles with stall_fetch=1

Behaviour:
Reset (reset=0, asynchronous):
- All counters 0, state RUN, stall_count 0.
- All outputs 0 while reset is low.

Timing and decode:
- Controls are combinational from the current inputs and registered state; decode samples them at the same posedge.
- Operand use from dec_instr[6:2]:
  - rs1+rs2: `OP_ARITH, `OP_BRANCH, `OP_STORE
  - rs1 only: `OP_IMM_ARITH, `OP_JALR, `OP_LOAD
  - none: `OP_LUI, `OP_AUIPC, `OP_JAL, `OP_FENCE, illegal
- Writes rd: ARITH, IMM_ARITH, LUI, AUIPC, JAL, JALR, LOAD, with rd!=0.
- x0 is never tracked and never hazards.

Hazard conditions:
- raw = dec_valid && a used rs has cnt[rs]!=0.
- waw_full = dec_valid && writes && cnt[rd] at maximum.

Output priority, highest first:
1. wb_exception or state DRAIN: flush_fetch, flush_decode and flush_execute = 1; stall_fetch = 1 in DRAIN.
2. ex_redirect or state FLUSH: flush_fetch = 1, flush_decode = 1.
3. mem_busy: stall_fetch = 1, stall_decode = 1.
4. raw or waw_full: stall_fetch = 1, insert_nop = 1.
5. Otherwise all controls 0.

Scoreboard:
- issue = dec_valid && state RUN && no priority 1–4 condition.
- On issue of an rd-writer: cnt[rd]+1 and inflight+1.
- On wb_release_valid: cnt[wb_release_rd]-1 and inflight-1.
- Same register incremented and released in the same cycle: net unchanged; same rule for inflight.
- Decrementing a zero counter saturates at 0. Assertion fails in simulation.
- The pipeline contract is exactly one release per issued writer, including flushed ones. This block never clears counters on flush.

FSM:
- RUN:
  - wb_exception -> DRAIN (takes precedence over ex_redirect).
  - ex_redirect -> FLUSH with fcnt = FLUSH_CYCLES-1; if FLUSH_CYCLES=1, stay in RUN.
- FLUSH:
  - fcnt counts down; at 0 -> RUN.
  - wb_exception -> DRAIN.
  - A new ex_redirect reloads fcnt.
- DRAIN:
  - Wait until inflight==0 with no release pending this cycle.
  - Then trap_go = 1 for one cycle and -> RUN.
  - Further wb_exception or ex_redirect are ignored.

Counters:
- stall_count increments on every cycle with stall_fetch=1.
- It wraps modulo 2^32.

Test Plan:
- Hazard-free stream: addi x1,x0,5 followed by a stream of independent instructions -> no stall, insert_nop=0 every cycle; cnt[1] 0->1 after issue, back to 0 on wb_release_rd=1.
- RAW: addi x3 issued, then add x4,x3,x2 at decode before release -> stall_fetch=1, insert_nop=1 each cycle until release of rd=3; issue the following cycle; stall_count = number of bubble cycles.
- x0 and no-operand: add x5,x0,x0 with cnt tracking ignored; lui x6 while x6 busy -> no RAW stall; with CNT_W=2, four outstanding writers to x6 -> waw_full stall on the fourth.
- Redirect, FLUSH_CYCLES=2: ex_redirect pulse -> flush_fetch and flush_decode high for exactly 2 cycles; simultaneous mem_busy -> flush wins, no stall_decode.
- Trap: 3 writers in flight, wb_exception pulse -> all three flushes high, state DRAIN; 3 releases (one coinciding with a new issue attempt, which is blocked); trap_go pulses exactly 1 cycle after inflight reaches 0; ex_redirect during DRAIN is ignored.
- Async reset mid-DRAIN: reset low between clock edges -> outputs 0 immediately; after release, state RUN, all counters 0, stall_count 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the in-order RV32I pipeline.
// Tracks in-flight destination writes per register, turns RAW/WAW hazards
// into execute bubbles, and sequences branch-redirect flushes and trap drains.

// Scoreboard sanity checker: a release must always target a register that
// has at least one writer in flight.
module pipeline_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic underflow
);
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !underflow);
endmodule

module pipeline_ctrl #(
  parameter int CNT_W        = 2,
  parameter int INF_W        = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dec_instr,
  input  logic        dec_valid,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  input  logic        wb_release_valid,
  input  logic [4:0]  wb_release_rd,
  input  logic        wb_exception,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        insert_nop,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        flush_execute,
  output logic        trap_go,
  output logic [31:0] stall_count
);

  // fcnt holds the number of FLUSH-state cycles still to go.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FCNT_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FCNT_ONE  = FC_W'(1);
  localparam logic [FC_W-1:0]  FCNT_ZERO = {FC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [INF_W-1:0] INF_ZERO  = {INF_W{1'b0}};
  localparam logic [INF_W-1:0] INF_ONE   = INF_W'(1);
  localparam logic [INF_W-1:0] INF_MAX   = {INF_W{1'b1}};

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_FENCE     = 5'b00011;
  localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
  localparam logic [4:0] OP_AUIPC     = 5'b00101;
  localparam logic [4:0] OP_STORE     = 5'b01000;
  localparam logic [4:0] OP_ARITH     = 5'b01100;
  localparam logic [4:0] OP_LUI       = 5'b01101;
  localparam logic [4:0] OP_BRANCH    = 5'b11000;
  localparam logic [4:0] OP_JALR      = 5'b11001;
  localparam logic [4:0] OP_JAL       = 5'b11011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic [4:0]  opcode_s, rs1_s, rs2_s, rd_s;
  logic        use_rs1_s, use_rs2_s, writes_op_s, writes_s;
  logic        raw_s, waw_full_s;
  logic        prio_trap_s, prio_flush_s;
  logic        issue_s, rel_valid_s, underflow_s;
  logic [31:0] inc_vec_s, dec_vec_s;
  logic        stall_fetch_s, stall_decode_s, insert_nop_s;
  logic        flush_fetch_s, flush_decode_s, flush_execute_s, trap_go_s;
  logic        unused_s;

  assign opcode_s = dec_instr[6:2];
  assign rd_s     = dec_instr[11:7];
  assign rs1_s    = dec_instr[19:15];
  assign rs2_s    = dec_instr[24:20];
  assign unused_s = ^{dec_instr[31:25], dec_instr[14:12], dec_instr[1:0]};

  // Classify the decode-stage instruction by operand use and rd write.
  always_comb begin
    use_rs1_s   = 1'b0;
    use_rs2_s   = 1'b0;
    writes_op_s = 1'b0;
    case (opcode_s)
      OP_ARITH: begin
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
        writes_op_s = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_IMM_ARITH, OP_JALR, OP_LOAD: begin
        use_rs1_s   = 1'b1;
        writes_op_s = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        writes_op_s = 1'b1;
      end
      OP_FENCE: begin
        writes_op_s = 1'b0;
      end
      default: begin
        writes_op_s = 1'b0;
      end
    endcase
  end

  // x0 is never tracked, so it can neither create nor suffer a hazard.
  assign writes_s   = writes_op_s && (rd_s != 5'd0);
  assign raw_s      = dec_valid &&
                      ((use_rs1_s && (rs1_s != 5'd0) && (cnt_q[rs1_s] != CNT_ZERO)) ||
                       (use_rs2_s && (rs2_s != 5'd0) && (cnt_q[rs2_s] != CNT_ZERO)));
  assign waw_full_s = dec_valid && writes_s && (cnt_q[rd_s] == CNT_MAX);

  assign prio_trap_s  = wb_exception || (state_q == ST_DRAIN);
  assign prio_flush_s = ex_redirect || (state_q == ST_FLUSH);
  assign rel_valid_s  = wb_release_valid && (wb_release_rd != 5'd0);

  // Prioritised pipeline controls; everything forced low while in reset.
  always_comb begin
    stall_fetch_s   = 1'b0;
    stall_decode_s  = 1'b0;
    insert_nop_s    = 1'b0;
    flush_fetch_s   = 1'b0;
    flush_decode_s  = 1'b0;
    flush_execute_s = 1'b0;
    trap_go_s       = 1'b0;
    issue_s         = 1'b0;
    if (!reset) begin
      issue_s = 1'b0;
    end else if (prio_trap_s) begin
      flush_fetch_s   = 1'b1;
      flush_decode_s  = 1'b1;
      flush_execute_s = 1'b1;
      stall_fetch_s   = (state_q == ST_DRAIN);
      trap_go_s       = (state_q == ST_DRAIN) && (inflight_q == INF_ZERO) && !wb_release_valid;
    end else if (prio_flush_s) begin
      flush_fetch_s  = 1'b1;
      flush_decode_s = 1'b1;
    end else if (mem_busy) begin
      stall_fetch_s  = 1'b1;
      stall_decode_s = 1'b1;
    end else if (raw_s || waw_full_s) begin
      stall_fetch_s = 1'b1;
      insert_nop_s  = 1'b1;
    end else begin
      issue_s = dec_valid && (state_q == ST_RUN);
    end
  end

  assign inc_vec_s = (issue_s && writes_s) ? (32'd1 << rd_s) : 32'd0;
  assign dec_vec_s = rel_valid_s ? (32'd1 << wb_release_rd) : 32'd0;

  // Per-register counters: issue adds, release subtracts, both cancel.
  always_comb begin
    underflow_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        cnt_d[i] = CNT_ZERO;
      end else if (inc_vec_s[i] && !dec_vec_s[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_vec_s[i] && !inc_vec_s[i]) begin
        if (cnt_q[i] != CNT_ZERO) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end else begin
          cnt_d[i]    = CNT_ZERO;
          underflow_s = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Total in-flight writers, saturating at both ends.
  always_comb begin
    inflight_d = inflight_q;
    if ((issue_s && writes_s) && !rel_valid_s) begin
      inflight_d = (inflight_q != INF_MAX) ? (inflight_q + INF_ONE) : inflight_q;
    end else if (rel_valid_s && !(issue_s && writes_s)) begin
      inflight_d = (inflight_q != INF_ZERO) ? (inflight_q - INF_ONE) : INF_ZERO;
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Stall performance counter, wrapping modulo 2^32.
  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall_fetch_s};
  end

  // Sequencer next state: exception drain beats redirect flush.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (wb_exception) begin
          state_d = ST_DRAIN;
          fcnt_d  = FCNT_ZERO;
        end else if (ex_redirect && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (wb_exception) begin
          state_d = ST_DRAIN;
          fcnt_d  = FCNT_ZERO;
        end else if (ex_redirect) begin
          fcnt_d = FCNT_LOAD;
        end else if (fcnt_q <= FCNT_ONE) begin
          state_d = ST_RUN;
          fcnt_d  = FCNT_ZERO;
        end else begin
          fcnt_d = fcnt_q - FCNT_ONE;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == INF_ZERO) && !wb_release_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = FCNT_ZERO;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= FCNT_ZERO;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Scoreboard and performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      inflight_q    <= INF_ZERO;
      stall_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      inflight_q    <= inflight_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_fetch   = stall_fetch_s;
  assign stall_decode  = stall_decode_s;
  assign insert_nop    = insert_nop_s;
  assign flush_fetch   = flush_fetch_s;
  assign flush_decode  = flush_decode_s;
  assign flush_execute = flush_execute_s;
  assign trap_go       = trap_go_s;
  assign stall_count   = stall_count_q;

  pipeline_ctrl_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .underflow (underflow_s)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: hand-written vector table for the
// directed scenarios, an async-reset-in-drain sequence, and a randomized
// phase against a queue-based reference model of the hazard rules.
module tb_pipeline_ctrl;
  localparam int CNT_W   = 2;
  localparam int INF_W   = 3;
  localparam int FC      = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dec_instr;
  logic        dec_valid, ex_redirect, mem_busy, wb_release_valid, wb_exception;
  logic [4:0]  wb_release_rd;
  logic        stall_fetch, stall_decode, insert_nop;
  logic        flush_fetch, flush_decode, flush_execute, trap_go;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .INF_W(INF_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .dec_instr(dec_instr), .dec_valid(dec_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .wb_release_valid(wb_release_valid), .wb_release_rd(wb_release_rd),
    .wb_exception(wb_exception), .stall_fetch(stall_fetch),
    .stall_decode(stall_decode), .insert_nop(insert_nop),
    .flush_fetch(flush_fetch), .flush_decode(flush_decode),
    .flush_execute(flush_execute), .trap_go(trap_go), .stall_count(stall_count)
  );

  int checks = 0;
  int failures = 0;
  string phase = "init";

  // Reference model: list of rd values still in flight, plus sequencing mode.
  logic [4:0]  pend_q [$];
  bit          m_drain;
  int          m_flush_left;
  logic [31:0] m_sc;
  logic [6:0]  last_act;

  typedef struct {
    logic [31:0] instr;
    bit          v, redir, busy, relv;
    logic [4:0]  relrd;
    bit          exc;
    logic [6:0]  exp; // {sf, sd, nop, ff, fd, fe, trap}
  } vec_t;
  vec_t tbl [$];

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd5, rs1, 3'd0, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd);
    return {20'h00001, rd, 7'b0110111};
  endfunction

  function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2, output bit wr);
    u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
    case (ins[6:2])
      5'b01100:                   begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
      5'b11000, 5'b01000:         begin u1 = 1'b1; u2 = 1'b1; end
      5'b00100, 5'b11001, 5'b00000: begin u1 = 1'b1; wr = 1'b1; end
      5'b01101, 5'b00101, 5'b11011: wr = 1'b1;
      default: wr = 1'b0;
    endcase
  endfunction

  function automatic int writers(input logic [4:0] r);
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i] == r) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s]: got 0x%0h expected 0x%0h", name, phase, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_drain = 1'b0;
    m_flush_left = 0;
    m_sc = 32'd0;
  endtask

  // One clock cycle: drive at negedge, compare before posedge, advance model.
  task automatic step(input logic [31:0] ins, input bit v, input bit redir, input bit busy,
                      input bit relv, input logic [4:0] relrd, input bit exc);
    bit u1, u2, wr, raw, waw, iss, trap;
    logic [6:0] e;
    logic [4:0] rs1, rs2, rd;
    int idx;
    @(negedge clk);
    dec_instr = ins; dec_valid = v; ex_redirect = redir; mem_busy = busy;
    wb_release_valid = relv; wb_release_rd = relrd; wb_exception = exc;
    #2;
    classify(ins, u1, u2, wr);
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    wr  = wr && (rd != 5'd0);
    raw = v && ((u1 && rs1 != 5'd0 && writers(rs1) > 0) || (u2 && rs2 != 5'd0 && writers(rs2) > 0));
    waw = v && wr && (writers(rd) >= CNT_MAX);
    e = 7'd0; iss = 1'b0;
    if (m_drain || exc)                  e = {m_drain, 6'b001110};
    else if (redir || m_flush_left > 0)  e = 7'b0001100;
    else if (busy)                       e = 7'b1100000;
    else if (raw || waw)                 e = 7'b1010000;
    else                                 iss = v;
    trap = m_drain && (pend_q.size() == 0) && !relv;
    e[0] = trap;
    last_act = {stall_fetch, stall_decode, insert_nop, flush_fetch, flush_decode, flush_execute, trap_go};
    chk("controls", 32'(last_act), 32'(e));
    chk("stall_count", stall_count, m_sc);
    m_sc = m_sc + 32'(e[6]);
    if (relv && relrd != 5'd0) begin
      idx = -1;
      foreach (pend_q[i]) if (idx < 0 && pend_q[i] == relrd) idx = i;
      if (idx >= 0) pend_q.delete(idx);
    end
    if (iss && wr) pend_q.push_back(rd);
    if (m_drain) begin
      if (trap) m_drain = 1'b0;
    end else if (exc) begin
      m_drain = 1'b1; m_flush_left = 0;
    end else if (redir) begin
      m_flush_left = FC - 1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end
  endtask

  task automatic add(input logic [31:0] ins, input bit v, input bit redir, input bit busy,
                     input bit relv, input logic [4:0] relrd, input bit exc, input logic [6:0] exp);
    vec_t r;
    r.instr = ins; r.v = v; r.redir = redir; r.busy = busy;
    r.relv = relv; r.relrd = relrd; r.exc = exc; r.exp = exp;
    tbl.push_back(r);
  endtask

  logic [4:0] ops [12];

  initial begin
    // Directed table: hazard-free, RAW, x0/WAW, redirect, trap drain
    add(enc_i(5'd1, 5'd0),       1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_i(5'd2, 5'd0),       1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_lui(5'd7),           1, 0, 0, 1, 5'd1,  0, 7'b0000000);
    add(enc_r(5'd9, 5'd0, 5'd0), 1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_r(5'd4, 5'd2, 5'd7), 1, 0, 0, 0, 5'd0,  0, 7'b1010000);
    add(enc_r(5'd4, 5'd2, 5'd7), 1, 0, 0, 1, 5'd2,  0, 7'b1010000);
    add(enc_r(5'd4, 5'd2, 5'd7), 1, 0, 0, 1, 5'd7,  0, 7'b1010000);
    add(enc_r(5'd4, 5'd2, 5'd7), 1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_r(5'd5, 5'd0, 5'd0), 1, 0, 0, 1, 5'd9,  0, 7'b0000000);
    add(enc_lui(5'd6),           1, 0, 0, 1, 5'd4,  0, 7'b0000000);
    add(enc_lui(5'd6),           1, 0, 0, 1, 5'd5,  0, 7'b0000000);
    add(enc_lui(5'd6),           1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_lui(5'd6),           1, 0, 0, 0, 5'd0,  0, 7'b1010000);
    add(enc_r(5'd10, 5'd6, 5'd0),1, 0, 0, 1, 5'd6,  0, 7'b1010000);
    add(enc_lui(5'd6),           1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_i(5'd11, 5'd0),      1, 1, 1, 0, 5'd0,  0, 7'b0001100);
    add(enc_i(5'd11, 5'd0),      1, 0, 1, 0, 5'd0,  0, 7'b0001100);
    add(enc_i(5'd11, 5'd0),      1, 0, 1, 0, 5'd0,  0, 7'b1100000);
    add(32'd0,                   0, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(enc_i(5'd12, 5'd0),      1, 0, 0, 0, 5'd0,  1, 7'b0001110);
    add(enc_i(5'd12, 5'd0),      1, 0, 0, 1, 5'd6,  0, 7'b1001110);
    add(32'd0,                   0, 1, 0, 0, 5'd0,  0, 7'b1001110);
    add(enc_i(5'd12, 5'd0),      1, 0, 0, 1, 5'd6,  0, 7'b1001110);
    add(32'd0,                   0, 0, 0, 1, 5'd6,  0, 7'b1001110);
    add(32'd0,                   0, 0, 0, 0, 5'd0,  0, 7'b1001111);
    add(enc_i(5'd13, 5'd0),      1, 0, 0, 0, 5'd0,  0, 7'b0000000);
    add(32'd0,                   0, 0, 0, 1, 5'd13, 0, 7'b0000000);

    ops[0] = 5'b01100; ops[1] = 5'b11000; ops[2]  = 5'b01000; ops[3]  = 5'b00100;
    ops[4] = 5'b11001; ops[5] = 5'b00000; ops[6]  = 5'b01101; ops[7]  = 5'b00101;
    ops[8] = 5'b11011; ops[9] = 5'b00011; ops[10] = 5'b11111; ops[11] = 5'b10110;

    // Reset: outputs low even with every input pushing for activity
    phase = "reset";
    reset = 1'b0; dec_instr = enc_r(5'd1, 5'd1, 5'd1); dec_valid = 1'b1;
    ex_redirect = 1'b1; mem_busy = 1'b1; wb_release_valid = 1'b0;
    wb_release_rd = 5'd0; wb_exception = 1'b1;
    model_reset();
    #3;
    chk("reset controls", 32'({stall_fetch, stall_decode, insert_nop, flush_fetch,
                               flush_decode, flush_execute, trap_go}), 32'd0);
    chk("reset stall_count", stall_count, 32'd0);
    @(negedge clk);
    reset = 1'b1; dec_valid = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0; wb_exception = 1'b0;

    phase = "table";
    foreach (tbl[i]) begin
      step(tbl[i].instr, tbl[i].v, tbl[i].redir, tbl[i].busy, tbl[i].relv, tbl[i].relrd, tbl[i].exc);
      chk($sformatf("table row %0d", i), 32'(last_act), 32'(tbl[i].exp));
    end
    @(posedge clk); #1;
    chk("table stall_count", stall_count, 32'd11);

    // Async reset asserted between edges while draining
    phase = "reset_in_drain";
    step(enc_i(5'd1, 5'd0), 1, 0, 0, 0, 5'd0, 0);
    step(32'd0, 0, 0, 0, 0, 5'd0, 1);
    step(32'd0, 0, 0, 0, 0, 5'd0, 0);
    chk("drain entered", 32'(last_act), 32'(7'b1001110));
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async reset controls", 32'({stall_fetch, stall_decode, insert_nop, flush_fetch,
                                     flush_decode, flush_execute, trap_go}), 32'd0);
    chk("async reset stall_count", stall_count, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(32'd0, 0, 0, 0, 0, 5'd0, 0);
    chk("post reset idle", 32'(last_act), 32'd0);
    step(32'd0, 0, 0, 0, 0, 5'd0, 1);
    chk("post reset exception", 32'(last_act), 32'(7'b0001110));
    step(32'd0, 0, 0, 0, 0, 5'd0, 0);
    chk("post reset immediate trap", 32'(last_act), 32'(7'b1001111));
    step(enc_r(5'd2, 5'd1, 5'd0), 1, 0, 0, 0, 5'd0, 0);
    chk("post reset x1 clear", 32'(last_act), 32'd0);
    @(posedge clk); #1;
    chk("post reset stall_count", stall_count, 32'd1);

    // Randomized traffic against the reference model
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      logic [4:0]  rrd;
      bit v, rd_x, bz, rv, ex;
      ins = $urandom;
      ins[1:0]   = 2'b11;
      ins[6:2]   = ops[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      v    = ($urandom_range(0, 3) != 0);
      rd_x = ($urandom_range(0, 19) == 0);
      bz   = ($urandom_range(0, 9) == 0);
      ex   = ($urandom_range(0, 49) == 0);
      rv   = 1'b0;
      rrd  = 5'($urandom_range(0, 31));
      if (pend_q.size() >= 6 || (pend_q.size() > 0 && $urandom_range(0, 2) == 0)) begin
        rv  = 1'b1;
        rrd = pend_q[$urandom_range(0, pend_q.size() - 1)];
      end
      step(ins, v, rd_x, bz, rv, rrd, ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
